// File: rtl/display_scan_mux.sv
// Four-digit 7-segment scan multiplexer: steps through the digits of a latched word,
// blanks every digit at the start of each slot, and swaps in newly loaded words only at a frame wrap.
module display_scan_mux #(
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic        load,
  input  logic        lz_blank,
  output logic        A,
  output logic        B,
  output logic        C,
  output logic        D,
  output logic [3:0]  dig_n,
  output logic        pend,
  output logic        frame_tick
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

  logic [15:0]      shadow_q, shadow_d;
  logic [15:0]      active_q, active_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       nib_q, nib_d;
  logic [3:0]       dig_n_q, dig_n_d;
  logic             pend_q, pend_d;
  logic             tick_q, tick_d;
  logic             last_slot, wrap, suppress;

  always_comb begin
    last_slot = (cnt_q == CNT_MAX);
    wrap      = last_slot && (idx_q == 2'd3);
    cnt_d     = last_slot ? '0 : cnt_q + 1'b1;
    idx_d     = last_slot ? idx_q + 2'd1 : idx_q;
    shadow_d  = load ? value : shadow_q;
    active_d  = active_q;
    pend_d    = pend_q;

    // A load on the wrap edge bypasses the shadow so it is visible in the new frame
    if (wrap) begin
      if (load)        active_d = value;
      else if (pend_q) active_d = shadow_q;
      pend_d = 1'b0;
    end else if (load) begin
      pend_d = 1'b1;
    end

    nib_d = nib_q;
    if (last_slot) nib_d = active_d[{idx_d, 2'b00} +: 4];

    suppress = lz_blank && (((idx_d == 2'd3) && (active_d[15:12] == 4'h0)) ||
                            ((idx_d == 2'd2) && (active_d[15:8]  == 8'h00)) ||
                            ((idx_d == 2'd1) && (active_d[15:4]  == 12'h000)));

    if ((cnt_d < BLANK_END) || suppress) dig_n_d = 4'b1111;
    else                                 dig_n_d = ~(4'b0001 << idx_d);

    tick_d = wrap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
      active_q <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      nib_q    <= '0;
      dig_n_q  <= 4'b1111;
      pend_q   <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      nib_q    <= nib_d;
      dig_n_q  <= dig_n_d;
      pend_q   <= pend_d;
      tick_q   <= tick_d;
    end
  end

  assign {A, B, C, D} = nib_q;
  assign dig_n        = dig_n_q;
  assign pend         = pend_q;
  assign frame_tick   = tick_q;

endmodule

// File: tb/tb_display_scan_mux.sv
// Scoreboard bench for display_scan_mux: a cycle-indexed reference model queues expected outputs,
// and a negedge monitor pops and compares them.
`timescale 1ns/100ps
module tb_display_scan_mux;

  localparam int P  = 8;
  localparam int BL = 2;
  localparam int FRAME = 4 * P;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] value = '0;
  logic        load = 1'b0;
  logic        lz_blank = 1'b1;
  logic        A, B, C, D;
  logic [3:0]  dig_n;
  logic        pend, frame_tick;
  logic        async_probe = 1'b0;

  display_scan_mux #(.PRESCALE(P), .BLANK_CYCLES(BL)) dut (
    .clk(clk), .rst(rst), .value(value), .load(load), .lz_blank(lz_blank),
    .A(A), .B(B), .C(C), .D(D), .dig_n(dig_n), .pend(pend), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] nib;
    logic [3:0] dig;
    logic       pnd;
    logic       tick;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: cycle number since reset release and the frame-level registers
  int          t_cyc = 0;
  logic [15:0] m_active = '0;
  logic [15:0] m_shadow = '0;
  logic        m_pend = 1'b0;

  function automatic exp_t expect_at(int n, logic [15:0] a, logic lz, logic p);
    exp_t e;
    int s = (n / P) % 4;
    int c = n % P;
    logic [15:0] sh;
    logic [3:0]  oh;
    sh = a >> (4 * s);
    e.nib = sh[3:0];
    oh = 4'b0001 << s;
    if (c < BL)                         e.dig = 4'b1111;
    else if (lz && s >= 1 && sh == 0)   e.dig = 4'b1111;
    else                                e.dig = ~oh;
    e.pnd  = p;
    e.tick = (n > 0) && (n % FRAME == 0);
    return e;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_t r;
      t_cyc    = 0;
      m_active = '0;
      m_shadow = '0;
      m_pend   = 1'b0;
      exp_q.delete();
      r.nib = 4'h0; r.dig = 4'b1111; r.pnd = 1'b0; r.tick = 1'b0;
      exp_q.push_back(r);
    end else begin
      if ((t_cyc + 1) % FRAME == 0) begin
        if (load)        m_active = value;
        else if (m_pend) m_active = m_shadow;
        m_pend = 1'b0;
      end else if (load) begin
        m_pend = 1'b1;
      end
      if (load) m_shadow = value;
      t_cyc = t_cyc + 1;
      exp_q.push_back(expect_at(t_cyc, m_active, lz_blank, m_pend));
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at t=%0t cycle %0d: got %0h expected %0h", name, $time, t_cyc, act, req);
    end
  endtask

  always @(negedge clk or posedge async_probe) begin
    if (async_probe) begin
      chk("async_rst_dig_n", int'(dig_n), 15);
      chk("async_rst_nibble", int'({A, B, C, D}), 0);
      chk("async_rst_pend", int'(pend), 0);
      chk("async_rst_tick", int'(frame_tick), 0);
    end else if (!rst) begin
      if (exp_q.size() == 0) begin
        chk("scoreboard_empty", 0, 1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("nibble", int'({A, B, C, D}), int'(e.nib));
        chk("dig_n", int'(dig_n), int'(e.dig));
        chk("pend", int'(pend), int'(e.pnd));
        chk("frame_tick", int'(frame_tick), int'(e.tick));
        chk("dig_n_lowcount_le1", ($countones(~dig_n) <= 1) ? 1 : 0, 1);
      end
    end
  end

  task automatic step_to(input int n);
    int guard = 0;
    while (t_cyc < n) begin
      @(posedge clk); #1;
      guard++;
      if (guard > 5000) begin
        $display("FAIL step_to timeout: cycle %0d expected %0d", t_cyc, n);
        $fatal(1, "step_to timeout");
      end
    end
  endtask

  task automatic pulse_load(input logic [15:0] v);
    value = v;
    load  = 1'b1;
    @(posedge clk); #1;
    load  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int mask_sel;
    logic [15:0] mask;
    #2;
    do_reset();

    step_to(5);
    pulse_load(16'h1234);
    step_to(40);
    pulse_load(16'h0050);
    step_to(100);
    pulse_load(16'h0000);
    step_to(159);
    pulse_load(16'hBEEF);
    step_to(165);
    pulse_load(16'h1111);
    step_to(180);
    pulse_load(16'h2222);

    // Async reset mid-slot while digit 2 is lit and a load is pending
    step_to(200);
    pulse_load(16'hBEEF);
    step_to(212);
    #2 rst = 1'b1;
    #1 async_probe = 1'b1;
    #0.5 async_probe = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) lz_blank = ~lz_blank;
      if ($urandom_range(0, 5) == 0) begin
        mask_sel = $urandom_range(0, 4);
        case (mask_sel)
          0: mask = 16'hFFFF;
          1: mask = 16'h0FFF;
          2: mask = 16'h00FF;
          3: mask = 16'h000F;
          default: mask = 16'h0000;
        endcase
        pulse_load(16'($urandom) & mask);
      end else begin
        @(posedge clk); #1;
      end
    end

    repeat (2) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
